// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: per-stage stall requests, exception/debug inputs, and the
// stall/flush/redirect/halt outputs shared with pc_reg and the pipeline registers.
interface pipeline_ctrl_if;
  logic        stall_request_id;
  logic        stall_request_ex;
  logic        stall_request_mem;
  logic        exception_signal;
  logic [31:0] exception_target;
  logic        halt_request;
  logic [5:0]  stall;
  logic        flush;
  logic        redirect_signal;
  logic [31:0] redirect_target;
  logic        halted;
  logic        stall_timeout;

  // Core side: raises requests, consumes sequencing outputs.
  modport master (
    output stall_request_id, stall_request_ex, stall_request_mem,
    output exception_signal, exception_target, halt_request,
    input  stall, flush, redirect_signal, redirect_target, halted, stall_timeout
  );

  // Controller side.
  modport slave (
    input  stall_request_id, stall_request_ex, stall_request_mem,
    input  exception_signal, exception_target, halt_request,
    output stall, flush, redirect_signal, redirect_target, halted, stall_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: merges stall requests, sequences one-cycle exception
// flushes with PC redirect, handles debug halt/resume and a sticky stall watchdog.
module pipeline_ctrl #(
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic               clock,
  input  logic               reset,
  pipeline_ctrl_if.slave     ctrl_bus
);

  localparam logic [1:0] StInit  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_d;
  logic [31:0] r_redirect_target;
  logic [7:0]  r_stall_count;
  logic [7:0]  w_stall_count_d;
  logic        r_stall_timeout;
  logic        w_any_request;
  logic        w_load_target;

  assign w_any_request = ctrl_bus.stall_request_id | ctrl_bus.stall_request_ex |
                         ctrl_bus.stall_request_mem;

  always_comb begin
    w_state_d     = r_state;
    w_load_target = 1'b0;
    case (r_state)
      StInit:  w_state_d = StRun;
      StRun: begin
        if (ctrl_bus.exception_signal) begin
          w_state_d     = StFlush;
          w_load_target = 1'b1;
        end else if (ctrl_bus.halt_request) begin
          w_state_d = StHalt;
        end
      end
      // The flush removes the exception source, so exception_signal is not sampled here.
      StFlush: w_state_d = ctrl_bus.halt_request ? StHalt : StRun;
      StHalt: begin
        if (ctrl_bus.exception_signal) begin
          w_state_d     = StFlush;
          w_load_target = 1'b1;
        end else if (!ctrl_bus.halt_request) begin
          w_state_d = StRun;
        end
      end
      default: w_state_d = StInit;
    endcase
  end

  always_comb begin
    w_stall_count_d = 8'd0;
    if (r_state == StRun && w_any_request) begin
      w_stall_count_d = (r_stall_count == 8'hff) ? 8'hff : r_stall_count + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state           <= StInit;
      r_redirect_target <= 32'h0;
      r_stall_count     <= 8'd0;
      r_stall_timeout   <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_stall_count <= w_stall_count_d;
      if (w_load_target) begin
        r_redirect_target <= ctrl_bus.exception_target;
      end
      if (w_stall_count_d == 8'(STALL_LIMIT)) begin
        r_stall_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_bus.stall = 6'b111111;
    case (r_state)
      StRun: begin
        if (ctrl_bus.stall_request_mem)     ctrl_bus.stall = 6'b011111;
        else if (ctrl_bus.stall_request_ex) ctrl_bus.stall = 6'b001111;
        else if (ctrl_bus.stall_request_id) ctrl_bus.stall = 6'b000111;
        else                                ctrl_bus.stall = 6'b000000;
      end
      StFlush: ctrl_bus.stall = 6'b000000;
      default: ctrl_bus.stall = 6'b111111;
    endcase
  end

  // Status outputs decode the state register only, never the inputs.
  assign ctrl_bus.flush           = (r_state == StFlush);
  assign ctrl_bus.redirect_signal = (r_state == StFlush);
  assign ctrl_bus.halted          = (r_state == StHalt);
  assign ctrl_bus.redirect_target = r_redirect_target;
  assign ctrl_bus.stall_timeout   = r_stall_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with STALL_LIMIT=4.
module tb_pipeline_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  pipeline_ctrl_if ctrl_bus ();

  pipeline_ctrl #(.STALL_LIMIT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .ctrl_bus (ctrl_bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    ctrl_bus.stall_request_id  = 1'b0;
    ctrl_bus.stall_request_ex  = 1'b0;
    ctrl_bus.stall_request_mem = 1'b0;
    ctrl_bus.exception_signal  = 1'b0;
    ctrl_bus.exception_target  = 32'h0;
    ctrl_bus.halt_request      = 1'b0;

    // Reset held for 3 cycles
    cycles(3);
    check("rst_stall",   32'(ctrl_bus.stall), 32'h3f);
    check("rst_flush",   32'(ctrl_bus.flush), 32'h0);
    check("rst_redir",   32'(ctrl_bus.redirect_signal), 32'h0);
    check("rst_target",  ctrl_bus.redirect_target, 32'h0);
    check("rst_halted",  32'(ctrl_bus.halted), 32'h0);
    check("rst_timeout", 32'(ctrl_bus.stall_timeout), 32'h0);
    reset = 1'b1;
    #1 check("init_stall", 32'(ctrl_bus.stall), 32'h3f);
    cycles(1);
    check("run_idle_stall", 32'(ctrl_bus.stall), 32'h00);

    // Combinational stall priority within one low phase
    ctrl_bus.stall_request_id = 1'b1;
    #1 check("prio_id", 32'(ctrl_bus.stall), 32'h07);
    ctrl_bus.stall_request_ex = 1'b1;
    #1 check("prio_ex", 32'(ctrl_bus.stall), 32'h0f);
    ctrl_bus.stall_request_mem = 1'b1;
    #1 check("prio_mem", 32'(ctrl_bus.stall), 32'h1f);
    ctrl_bus.stall_request_id  = 1'b0;
    ctrl_bus.stall_request_ex  = 1'b0;
    ctrl_bus.stall_request_mem = 1'b0;
    #1 check("prio_none", 32'(ctrl_bus.stall), 32'h00);

    // Exception from RUN
    cycles(1);
    ctrl_bus.exception_signal = 1'b1;
    ctrl_bus.exception_target = 32'h0000_0180;
    #1 check("exc_flush_not_comb", 32'(ctrl_bus.flush), 32'h0);
    cycles(1);
    ctrl_bus.exception_signal = 1'b0;
    check("exc_flush",  32'(ctrl_bus.flush), 32'h1);
    check("exc_redir",  32'(ctrl_bus.redirect_signal), 32'h1);
    check("exc_target", ctrl_bus.redirect_target, 32'h180);
    check("exc_stall",  32'(ctrl_bus.stall), 32'h00);
    cycles(1);
    check("exc_done_flush", 32'(ctrl_bus.flush), 32'h0);
    check("exc_hold_target", ctrl_bus.redirect_target, 32'h180);

    // Exception with mem stall held throughout
    ctrl_bus.stall_request_mem = 1'b1;
    ctrl_bus.exception_signal  = 1'b1;
    ctrl_bus.exception_target  = 32'h0000_0200;
    cycles(1);
    ctrl_bus.exception_signal = 1'b0;
    check("excm_flush",  32'(ctrl_bus.flush), 32'h1);
    check("excm_stall",  32'(ctrl_bus.stall), 32'h00);
    check("excm_target", ctrl_bus.redirect_target, 32'h200);
    cycles(1);
    check("excm_single_flush", 32'(ctrl_bus.flush), 32'h0);
    check("excm_run_stall",    32'(ctrl_bus.stall), 32'h1f);
    ctrl_bus.stall_request_mem = 1'b0;
    cycles(1);

    // Halt, exception during halt, resume
    ctrl_bus.halt_request = 1'b1;
    #1 check("halt_not_comb", 32'(ctrl_bus.halted), 32'h0);
    cycles(1);
    check("halt_halted", 32'(ctrl_bus.halted), 32'h1);
    check("halt_stall",  32'(ctrl_bus.stall), 32'h3f);
    ctrl_bus.exception_signal = 1'b1;
    ctrl_bus.exception_target = 32'h0000_0300;
    cycles(1);
    ctrl_bus.exception_signal = 1'b0;
    check("hexc_flush",  32'(ctrl_bus.flush), 32'h1);
    check("hexc_halted", 32'(ctrl_bus.halted), 32'h0);
    check("hexc_target", ctrl_bus.redirect_target, 32'h300);
    cycles(1);
    check("hexc_rehalt", 32'(ctrl_bus.halted), 32'h1);
    check("hexc_rehalt_flush", 32'(ctrl_bus.flush), 32'h0);
    ctrl_bus.halt_request = 1'b0;
    cycles(1);
    check("resume_halted", 32'(ctrl_bus.halted), 32'h0);
    check("resume_stall",  32'(ctrl_bus.stall), 32'h00);

    // Watchdog: 3 stalled edges stay below the limit
    ctrl_bus.stall_request_ex = 1'b1;
    cycles(3);
    ctrl_bus.stall_request_ex = 1'b0;
    check("wd3_timeout", 32'(ctrl_bus.stall_timeout), 32'h0);
    cycles(1);
    check("wd3_after", 32'(ctrl_bus.stall_timeout), 32'h0);
    // 4 stalled edges reach the limit; flag is sticky
    ctrl_bus.stall_request_ex = 1'b1;
    cycles(3);
    check("wd4_early", 32'(ctrl_bus.stall_timeout), 32'h0);
    cycles(1);
    ctrl_bus.stall_request_ex = 1'b0;
    check("wd4_timeout", 32'(ctrl_bus.stall_timeout), 32'h1);
    cycles(2);
    check("wd4_sticky", 32'(ctrl_bus.stall_timeout), 32'h1);

    // Async reset pulse mid-FLUSH
    ctrl_bus.exception_signal = 1'b1;
    ctrl_bus.exception_target = 32'h0000_0400;
    cycles(1);
    ctrl_bus.exception_signal = 1'b0;
    check("arst_pre_flush", 32'(ctrl_bus.flush), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("arst_flush",   32'(ctrl_bus.flush), 32'h0);
    check("arst_redir",   32'(ctrl_bus.redirect_signal), 32'h0);
    check("arst_target",  ctrl_bus.redirect_target, 32'h0);
    check("arst_stall",   32'(ctrl_bus.stall), 32'h3f);
    check("arst_timeout", 32'(ctrl_bus.stall_timeout), 32'h0);
    check("arst_halted",  32'(ctrl_bus.halted), 32'h0);
    cycles(2);
    reset = 1'b1;
    cycles(2);
    check("post_rst_redir", 32'(ctrl_bus.redirect_signal), 32'h0);
    check("post_rst_stall", 32'(ctrl_bus.stall), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencing controller for the five-stage CPU core. Merges per-stage stall requests into the shared `stall` vector consumed by pc_reg and every pipeline register. Sequences exception flushes with a one-cycle redirect of the program counter, and supports debug halt/resume. A watchdog flags stalls that persist abnormally long.

## Interface

Parameters:
- `STALL_LIMIT`, default 64: number of consecutive stalled cycles after which `stall_timeout` is set; legal range 2..255.

Ports:
- `clock`  input  1  the single core clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
- `stall_request_id`  input  1  decode stage needs a bubble (load-use hazard).
- `stall_request_ex`  input  1  execute stage is busy (multi-cycle mult/div).
- `stall_request_mem`  input  1  memory stage is waiting on the bus.
- `exception_signal`  input  1  level; the commit stage has taken an exception.
- `exception_target`  input  32  handler address accompanying `exception_signal`.
- `halt_request`  input  1  level; debug request to freeze the pipeline.
- `stall`  output  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 holds that stage.
- `flush`  output  1  clears all pipeline registers this cycle.
- `redirect_signal`  output  1  PC loads `redirect_target` this cycle instead of PC+4.
- `redirect_target`  output  32  registered handler address.
- `halted`  output  1  pipeline frozen by debug halt.
- `stall_timeout`  output  1  sticky watchdog flag.

## Operation

- States: INIT, RUN, FLUSH, HALT. The state register resets to INIT.
- INIT:
  - `stall` = 6'b111111.
  - Goes to RUN at the first rising edge with `reset` high.
- RUN: `stall` is combinational from the requests, highest stage wins:
  - mem → 6'b011111
  - else ex → 6'b001111
  - else id → 6'b000111
  - else 6'b000000
- RUN transitions, with priority exception > halt:
  - `exception_signal`=1 → FLUSH; `redirect_target` <= `exception_target` on the same edge.
  - else `halt_request`=1 → HALT.
- FLUSH: lasts exactly one cycle.
  - `flush`=1, `redirect_signal`=1, `stall`=6'b000000; stall requests are ignored.
  - Next state is HALT if `halt_request`=1, else RUN.
  - `exception_signal` is ignored in FLUSH, because the flush removes its source.
- HALT:
  - `stall`=6'b111111, `halted`=1.
  - `halt_request`=0 → RUN.
  - `exception_signal`=1 in HALT → FLUSH, and the halt is re-entered after the flush if still requested.
- Watchdog:
  - 8-bit `stall_count` increments each edge in RUN while any request is 1; it saturates at 255.
  - It clears in any cycle with no request, and in FLUSH, HALT and INIT.
  - When the count reaches `STALL_LIMIT`, `stall_timeout` <= 1 and stays 1 until reset.
- `redirect_target` holds its value outside FLUSH.

## Timing

Reset values, asserted asynchronously while `reset`=0:
- `stall`=6'b111111, `flush`=0, `redirect_signal`=0, `redirect_target`=32'h0, `halted`=0, `stall_timeout`=0, `stall_count`=0.

Latency:
- Stall requests → `stall`: combinational, 0 cycles, in RUN only.
- `exception_signal` high before edge N → `flush`/`redirect_signal` high during cycle N..N+1, and pc_reg loads the target at edge N+1.
- `halt_request` → `halted`: one edge.
- Resume → `stall` released: one edge.

Other timing rules:
- `flush`, `redirect_signal` and `halted` are decoded from the state register only, so they are glitch-free and never combinational from inputs.
- A simultaneous exception and halt in RUN gives FLUSH first, then HALT.
- Reset asserted mid-FLUSH drops `flush`/`redirect_signal` immediately. No redirect is replayed after reset.

## Test plan

- Reset release: hold `reset`=0 for 3 cycles and check the reset values; release it → `stall`=111111 for one cycle, then 000000 with idle requests.
- Stall priority: drive id=1 → 000111; id+ex → 001111; id+ex+mem → 011111; all 0 → 000000, all combinational in the same cycle.
- Exception: `exception_signal`=1, `exception_target`=32'h0000_0180 for one cycle → the next cycle has `flush`=1, `redirect_signal`=1, `redirect_target`=32'h180 and `stall`=0, then RUN. Repeat with `stall_request_mem`=1 held throughout, and confirm the flush is still single-cycle.
- Halt/resume: raise `halt_request` → `halted`=1 and `stall`=111111 from the next cycle; drop it → RUN one edge later. Exception during HALT → FLUSH, then back to HALT.
- Watchdog with `STALL_LIMIT`=4: ex request held 3 cycles then dropped → `stall_timeout`=0. Held 4 cycles → `stall_timeout`=1, which remains 1 after the request drops and clears only on `reset`=0.
- Async reset mid-FLUSH: pulse `reset` low between edges → all outputs at reset values immediately, independent of `clock`.
